// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential 16x16 shift-and-add multiplier (low 16 bits kept)
// that borrows a shared ALU for every add and shift step.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op_a, op_b     request and operands, sampled only in IDLE
//   busy, done, product   status, one-cycle completion pulse, held result
//   alu_req, alu_grant    shared-ALU handshake
//   alu_operand_A/B       ALU operands
//   alu_control           ALU opcode (0 = ADD, 5 = SHIFTLEFT)
//   alu_result            combinational ALU result
//
// Configuration:
//   ALU_MUL_EARLY_EXIT_EN  when defined, finish as soon as the remaining
//                          multiplier bits are all zero (data-dependent
//                          latency); otherwise always run 16 iterations.
//
// All outputs are registered from the next-state values, so each output
// reflects the state the block is in during that cycle.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_req,
  input  logic        alu_grant,
  output logic [15:0] alu_operand_A,
  output logic [15:0] alu_operand_B,
  output logic [3:0]  alu_control,
  input  logic [15:0] alu_result
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned OPW   = 4;
  localparam logic [CW-1:0]  ITERS   = CW'(DW);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  m_q, m_d;
  logic [DW-1:0]  q_q, q_d;
  logic [DW-1:0]  p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  product_q, product_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           req_q, req_d;
  logic [DW-1:0]  opa_q, opa_d;
  logic [DW-1:0]  opb_q, opb_d;
  logic [OPW-1:0] ctl_q, ctl_d;
  logic           finish_c;

  // Iteration exit condition evaluated in CHECK
  always_comb begin
`ifdef ALU_MUL_EARLY_EXIT_EN
    finish_c = (cnt_q == ITERS) || (q_q == '0);
`else
    finish_c = (cnt_q == ITERS);
`endif
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = op_a;
          q_d     = op_b;
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (finish_c) begin
          // Result is published together with the done pulse
          product_d = p_q;
          state_d   = S_DONE;
        end else if (q_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD: begin
        if (alu_grant) begin
          p_d     = alu_result;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (alu_grant) begin
          m_d     = alu_result;
          q_d     = q_q >> 1;
          cnt_d   = CW'(cnt_q + CW'(1));
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = 1'b0;
    opa_d  = '0;
    opb_d  = '0;
    ctl_d  = '0;
    // ALU drive derives from the next register values, so it stays
    // constant across stalled cycles
    if (state_d == S_ADD) begin
      req_d = 1'b1;
      opa_d = p_d;
      opb_d = m_d;
      ctl_d = OP_ADD;
    end else if (state_d == S_SHIFT) begin
      req_d = 1'b1;
      opa_d = m_d;
      opb_d = DW'(1);
      ctl_d = OP_SHL;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      ctl_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      ctl_q     <= ctl_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign product       = product_q;
  assign alu_req       = req_q;
  assign alu_operand_A = opa_q;
  assign alu_operand_B = opb_q;
  assign alu_control   = ctl_q;

endmodule
